// File: rtl/pos_cell_port_ctrl_pkg.sv
// pos_cell_port_ctrl_pkg: FSM state encoding and RAM timing shared by the cell port controller
package pos_cell_port_ctrl_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE        = 3'd0;
  localparam state_t S_RD_CNT      = 3'd1;
  localparam state_t S_RD_CNT_WAIT = 3'd2;
  localparam state_t S_RD_STREAM   = 3'd3;
  localparam state_t S_RD_DRAIN    = 3'd4;
  localparam state_t S_WR_STREAM   = 3'd5;
  localparam state_t S_WR_CNT      = 3'd6;
  localparam int RD_LAT = 2;
endpackage

// File: rtl/pos_cell_port_ctrl_if.sv
// pos_cell_port_ctrl_if: read stream, write stream and cell-RAM bus of the port controller
interface pos_cell_port_ctrl_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_start;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] rd_id;
  logic                  rd_last;
  logic                  rd_done;
  logic                  wr_start;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  wr_ready;
  logic                  wr_done;
  logic                  busy;
  logic                  err_ovf;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;
  modport master (
    input  rd_start, wr_start, wr_valid, wr_data, wr_last, mem_q,
    output rd_valid, rd_data, rd_id, rd_last, rd_done, wr_ready, wr_done, busy, err_ovf,
           mem_address, mem_data, mem_rden, mem_wren
  );
  modport slave (
    output rd_start, wr_start, wr_valid, wr_data, wr_last, mem_q,
    input  rd_valid, rd_data, rd_id, rd_last, rd_done, wr_ready, wr_done, busy, err_ovf,
           mem_address, mem_data, mem_rden, mem_wren
  );
endinterface

// File: rtl/pos_cell_rd_tracker.sv
// pos_cell_rd_tracker: delays issue valid/id/last by the RAM latency so they line up with mem_q
module pos_cell_rd_tracker
  import pos_cell_port_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_id,
  input  logic                  issue_last,
  output logic                  ret_valid,
  output logic [ADDR_WIDTH-1:0] ret_id,
  output logic                  ret_last
);
  logic [RD_LAT-1:0] v;
  logic [RD_LAT-1:0] l;
  logic [ADDR_WIDTH-1:0] id [RD_LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      l <= '0;
      for (int i = 0; i < RD_LAT; i++) id[i] <= '0;
    end else begin
      v <= {v[RD_LAT-2:0], issue_valid};
      l <= {l[RD_LAT-2:0], issue_valid && issue_last};
      id[0] <= issue_id;
      for (int i = 1; i < RD_LAT; i++) id[i] <= id[i-1];
    end
  end
  assign ret_valid = v[RD_LAT-1];
  assign ret_last  = l[RD_LAT-1];
  assign ret_id    = id[RD_LAT-1];
endmodule

// File: rtl/pos_cell_port_ctrl.sv
// pos_cell_port_ctrl: arbitrates read/write sessions over one cell RAM whose word 0 holds the particle count
module pos_cell_port_ctrl
  import pos_cell_port_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input logic clk,
  input logic rst,
  pos_cell_port_ctrl_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] MAX_ID = ADDR_WIDTH'(PARTICLE_NUM - 1);
  state_t state;
  logic rd_pend, wr_pend, prio_wr, rd_done_q, err_ovf_q;
  logic [ADDR_WIDTH-1:0] count, rd_ptr;
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [1:0] wait_cnt;
  logic idle, gr_rd, gr_wr, cnt_sample, cnt_ovf, wr_acc, wr_fit, wr_store;
  logic [ADDR_WIDTH-1:0] raw_cnt, cnt_val;
  logic trk_valid, trk_last;
  logic [ADDR_WIDTH-1:0] trk_id;
  assign idle       = state == S_IDLE;
  // prio_wr only moves on contended grants, so read wins the first tie after reset
  assign gr_rd      = idle && rd_pend && (!wr_pend || !prio_wr);
  assign gr_wr      = idle && wr_pend && !gr_rd;
  assign cnt_sample = state == S_RD_CNT_WAIT && wait_cnt == 2'(RD_LAT - 1);
  assign raw_cnt    = bus.mem_q[ADDR_WIDTH-1:0];
  assign cnt_ovf    = raw_cnt > MAX_ID;
  assign cnt_val    = cnt_ovf ? MAX_ID : raw_cnt;
  assign wr_acc     = state == S_WR_STREAM && bus.wr_valid;
  assign wr_fit     = wr_ptr <= {1'b0, MAX_ID};
  assign wr_store   = wr_acc && wr_fit;
  pos_cell_rd_tracker #(.ADDR_WIDTH(ADDR_WIDTH)) u_trk (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(state == S_RD_STREAM),
    .issue_id   (rd_ptr),
    .issue_last (rd_ptr == count),
    .ret_valid  (trk_valid),
    .ret_id     (trk_id),
    .ret_last   (trk_last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      prio_wr   <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      wait_cnt  <= '0;
      rd_done_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      rd_pend   <= gr_rd ? 1'b0 : rd_pend | bus.rd_start;
      wr_pend   <= gr_wr ? 1'b0 : wr_pend | bus.wr_start;
      if (idle && rd_pend && wr_pend) prio_wr <= gr_rd;
      rd_done_q <= (cnt_sample && cnt_val == '0) || (state == S_RD_DRAIN && trk_last);
      if ((cnt_sample && cnt_ovf) || (wr_acc && !wr_fit)) err_ovf_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (gr_rd) state <= S_RD_CNT;
          else if (gr_wr) begin
            state  <= S_WR_STREAM;
            wr_ptr <= (ADDR_WIDTH+1)'(1);
          end
        end
        S_RD_CNT: begin
          state    <= S_RD_CNT_WAIT;
          wait_cnt <= '0;
        end
        S_RD_CNT_WAIT: begin
          if (cnt_sample) begin
            count  <= cnt_val;
            rd_ptr <= ADDR_WIDTH'(1);
            state  <= cnt_val == '0 ? S_IDLE : S_RD_STREAM;
          end else wait_cnt <= wait_cnt + 2'd1;
        end
        S_RD_STREAM: begin
          if (rd_ptr == count) state <= S_RD_DRAIN;
          else rd_ptr <= rd_ptr + 1'b1;
        end
        S_RD_DRAIN: if (trk_last) state <= S_IDLE;
        S_WR_STREAM: begin
          if (wr_store) wr_ptr <= wr_ptr + 1'b1;
          if (wr_acc && bus.wr_last) state <= S_WR_CNT;
        end
        S_WR_CNT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  // wr_ptr runs one ahead of the stored-beat count
  assign bus.mem_rden    = state == S_RD_CNT || state == S_RD_STREAM;
  assign bus.mem_wren    = wr_store || state == S_WR_CNT;
  assign bus.mem_address = state == S_RD_STREAM ? rd_ptr : wr_store ? wr_ptr[ADDR_WIDTH-1:0] : '0;
  assign bus.mem_data    = wr_store ? bus.wr_data : state == S_WR_CNT ? DATA_WIDTH'(wr_ptr - 1'b1) : '0;
  assign bus.wr_ready    = state == S_WR_STREAM;
  assign bus.wr_done     = state == S_WR_CNT;
  assign bus.busy        = !idle;
  assign bus.err_ovf     = err_ovf_q;
  assign bus.rd_done     = rd_done_q;
  assign bus.rd_valid    = trk_valid;
  assign bus.rd_last     = trk_valid && trk_last;
  assign bus.rd_id       = trk_valid ? trk_id : '0;
  assign bus.rd_data     = trk_valid ? bus.mem_q : '0;
endmodule

// File: tb/tb_pos_cell_port_ctrl.sv
// tb_pos_cell_port_ctrl: directed bench with a 2-cycle-latency cell RAM model
module tb_pos_cell_port_ctrl;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pos_cell_port_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  pos_cell_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  function automatic logic [DW-1:0] pat(input int i);
    return {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
  endfunction
  function automatic logic [DW-1:0] wpat(input int i);
    return {32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i), 32'h7000_0000 + 32'(i)};
  endfunction
  logic [DW-1:0] mem [PN];
  logic [DW-1:0] q1;
  logic fill_en = 1'b0;
  logic [DW-1:0] fill_w0 = '0;
  logic poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  int wr_seen = 0;
  always @(posedge clk) begin
    q1 <= (bus.mem_rden && int'(bus.mem_address) < PN) ? mem[bus.mem_address] : '0;
    bus.mem_q <= q1;
    if (fill_en) begin
      mem[0] <= fill_w0;
      for (int i = 1; i < PN; i++) mem[i] <= pat(i);
    end else if (poke_en) mem[poke_addr] <= poke_data;
    else if (bus.mem_wren && int'(bus.mem_address) < PN) begin
      mem[bus.mem_address] <= bus.mem_data;
      wr_seen <= wr_seen + 1;
    end
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int q_id[$];
  logic [DW-1:0] q_data[$];
  logic q_last[$];
  int q_cyc[$];
  int done_n = 0, done_cyc = 0, wdone_n = 0, busy_rise = 0;
  logic busy_d = 1'b0;
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      q_id.push_back(int'(bus.rd_id));
      q_data.push_back(bus.rd_data);
      q_last.push_back(bus.rd_last);
      q_cyc.push_back(cyc);
    end
    if (bus.rd_done) begin
      done_n = done_n + 1;
      done_cyc = cyc;
    end
    if (bus.wr_done) wdone_n = wdone_n + 1;
    if (bus.busy && !busy_d) busy_rise = cyc;
    busy_d = bus.busy;
  end
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic pulse_rd();
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
  endtask
  task automatic pulse_wr();
    bus.wr_start = 1'b1;
    tick();
    bus.wr_start = 1'b0;
  endtask
  task automatic wait_done(input int n0, input string tag);
    for (int i = 0; i < 600 && done_n == n0; i++) tick();
    chk(tag, done_n, n0 + 1);
  endtask
  task automatic wait_ready(input string tag);
    for (int i = 0; i < 50 && !bus.wr_ready; i++) tick();
    chk(tag, bus.wr_ready, 1);
  endtask
  task automatic fill(input logic [DW-1:0] w0);
    fill_w0 = w0;
    fill_en = 1'b1;
    tick();
    fill_en = 1'b0;
  endtask
  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en = 1'b1;
    tick();
    poke_en = 1'b0;
  endtask
  task automatic write_beat(input logic [DW-1:0] d, input logic last, input int addr, input string tag);
    bus.wr_valid = 1'b1;
    bus.wr_data = d;
    bus.wr_last = last;
    #1;
    chk({tag, "_wren"}, bus.mem_wren, 1);
    chk({tag, "_addr"}, bus.mem_address, addr);
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int base, d0, w0, ws0, bad;
    bus.rd_start = 1'b0;
    bus.wr_start = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.wr_last = 1'b0;
    fill(DW'(3));
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rden", bus.mem_rden, 0);
    chk("rst_wren", bus.mem_wren, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_err_ovf", bus.err_ovf, 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    rst = 1'b0;
    tick();
    // three-particle read
    base = q_id.size();
    d0 = done_n;
    pulse_rd();
    wait_done(d0, "t1_done");
    chk("t1_beats", q_id.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_id", q_id[base+k], k + 1);
      chk("t1_data", q_data[base+k], pat(k + 1));
      chk("t1_last", q_last[base+k], k == 2);
    end
    chk("t1_consec", q_cyc[base+2] - q_cyc[base], 2);
    chk("t1_latency", q_cyc[base] - busy_rise, 5);
    chk("t1_done_after_last", done_cyc - q_cyc[base+2], 1);
    // empty cell: RD_CNT issue, two wait cycles, then rd_done
    poke(0, '0);
    base = q_id.size();
    d0 = done_n;
    pulse_rd();
    wait_done(d0, "t2_done");
    chk("t2_beats", q_id.size() - base, 0);
    chk("t2_done_lat", done_cyc - busy_rise, 3);
    chk("t2_busy", bus.busy, 0);
    // five-beat write with a bubble after beat 2
    w0 = wdone_n;
    pulse_wr();
    wait_ready("t3_ready");
    write_beat(wpat(1), 1'b0, 1, "t3_b1");
    write_beat(wpat(2), 1'b0, 2, "t3_b2");
    #1;
    chk("t3_gap_wren", bus.mem_wren, 0);
    chk("t3_gap_ready", bus.wr_ready, 1);
    tick();
    write_beat(wpat(3), 1'b0, 3, "t3_b3");
    write_beat(wpat(4), 1'b0, 4, "t3_b4");
    write_beat(wpat(5), 1'b1, 5, "t3_b5");
    chk("t3_wr_done", bus.wr_done, 1);
    chk("t3_cnt_wren", bus.mem_wren, 1);
    chk("t3_cnt_addr", bus.mem_address, 0);
    chk("t3_cnt_data", bus.mem_data, 5);
    chk("t3_cnt_ready", bus.wr_ready, 0);
    chk("t3_cnt_rden", bus.mem_rden, 0);
    tick();
    chk("t3_busy", bus.busy, 0);
    chk("t3_wdone_n", wdone_n - w0, 1);
    chk("t3_mem0", mem[0], 5);
    base = q_id.size();
    d0 = done_n;
    pulse_rd();
    wait_done(d0, "t3_rd_done");
    chk("t3_rd_beats", q_id.size() - base, 5);
    for (int k = 0; k < 5; k++) chk("t3_rd_data", q_data[base+k], wpat(k + 1));
    // simultaneous requests: read first after reset, then write next tie
    do_reset();
    poke(0, DW'(1));
    d0 = done_n;
    w0 = wdone_n;
    bus.rd_start = 1'b1;
    bus.wr_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    bus.wr_start = 1'b0;
    wait_done(d0, "t4_rd_first");
    chk("t4_no_wr_yet", wdone_n, w0);
    chk("t4_ready_low", bus.wr_ready, 0);
    tick();
    chk("t4_wr_next", bus.wr_ready, 1);
    write_beat(wpat(9), 1'b1, 1, "t4_w1");
    chk("t4_wr_done", bus.wr_done, 1);
    tick();
    d0 = done_n;
    base = q_id.size();
    bus.rd_start = 1'b1;
    bus.wr_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    bus.wr_start = 1'b0;
    wait_ready("t4_wr_first");
    chk("t4_rd_not_first", done_n, d0);
    write_beat(wpat(10), 1'b1, 1, "t4_w2");
    tick();
    wait_done(d0, "t4_rd_second");
    chk("t4_rd_beats", q_id.size() - base, 1);
    chk("t4_rd_data", q_data[base], wpat(10));
    // count clamp on read, then overlong write
    fill(DW'(250));
    base = q_id.size();
    d0 = done_n;
    pulse_rd();
    wait_done(d0, "t5_rd_done");
    chk("t5_beats", q_id.size() - base, 219);
    chk("t5_last_id", q_id[base+218], 219);
    chk("t5_last_flag", q_last[base+218], 1);
    bad = 0;
    for (int k = 0; k < 219; k++)
      if (q_data[base+k] !== pat(k + 1) || q_id[base+k] != k + 1 || q_last[base+k] !== (k == 218)) bad++;
    chk("t5_stream", bad, 0);
    chk("t5_rd_ovf", bus.err_ovf, 1);
    do_reset();
    chk("t5_ovf_cleared", bus.err_ovf, 0);
    ws0 = wr_seen;
    pulse_wr();
    wait_ready("t5_ready");
    bad = 0;
    for (int k = 1; k <= 221; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data = wpat(k);
      bus.wr_last = k == 221;
      #1;
      if (k == 220) chk("t5_ovf_before", bus.err_ovf, 0);
      if (bus.mem_wren !== (k <= 219) || (k <= 219 && int'(bus.mem_address) != k) || bus.wr_ready !== 1'b1) bad++;
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.wr_last = 1'b0;
    chk("t5_beats_wr", bad, 0);
    chk("t5_cnt_data", bus.mem_data, 219);
    chk("t5_wr_done", bus.wr_done, 1);
    tick();
    chk("t5_mem0", mem[0], 219);
    chk("t5_mem219", mem[219], wpat(219));
    chk("t5_wr_ovf", bus.err_ovf, 1);
    chk("t5_writes", wr_seen - ws0, 220);
    // reset in the middle of a ten-particle stream
    fill(DW'(10));
    pulse_rd();
    for (int i = 0; i < 50 && !(bus.rd_valid && bus.rd_id == 2); i++) tick();
    chk("t6_reach_id2", bus.rd_id, 2);
    rst = 1'b1;
    base = q_id.size();
    tick();
    chk("t6_busy", bus.busy, 0);
    chk("t6_ovf", bus.err_ovf, 0);
    chk("t6_valid", bus.rd_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_no_stale", q_id.size() - base, 0);
    poke(0, DW'(3));
    base = q_id.size();
    d0 = done_n;
    pulse_rd();
    wait_done(d0, "t6_rd_done");
    chk("t6_beats", q_id.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      chk("t6_id", q_id[base+k], k + 1);
      chk("t6_data", q_data[base+k], pat(k + 1));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pos_cell_port_ctrl.md
POS_CELL_PORT_CTRL -- requirements
Module: pos_cell_port_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, meaning one cell-RAM word {posz, posy, posx}.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning cell-RAM address width.
REQ-003 SHALL have parameter PARTICLE_NUM, default 220, meaning cell-RAM depth; address 0 holds the particle count.
REQ-004 SHALL run on one clock; reset is synchronous and active-high.
REQ-005 Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- rd_start  in  1  pulse requesting a full read of the cell.
- rd_valid  out  1  rd_data is a valid particle.
- rd_data  out  DATA_WIDTH  particle position.
- rd_id  out  ADDR_WIDTH  RAM address of rd_data (1..count).
- rd_last  out  1  with rd_valid, marks the final particle.
- rd_done  out  1  one-cycle pulse at read-session end.
- wr_start  in  1  pulse requesting a write session.
- wr_valid  in  1  writer beat valid.
- wr_data  in  DATA_WIDTH  particle to store.
- wr_last  in  1  final beat of the write session.
- wr_ready  out  1  beat accepted when wr_valid && wr_ready.
- wr_done  out  1  one-cycle pulse after the count word is written.
- busy  out  1  FSM not in IDLE.
- err_ovf  out  1  sticky: count clamp or write beat dropped.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_data  out  DATA_WIDTH  RAM write data.
- mem_rden  out  1  RAM read enable.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DATA_WIDTH  RAM read data; 2-cycle latency from address/rden.

Function
REQ-006 SHALL implement FSM states IDLE, RD_CNT, RD_CNT_WAIT, RD_STREAM, RD_DRAIN, WR_STREAM, WR_CNT.
REQ-007 SHALL latch rd_start and wr_start into one-deep pending flags; a pulse arriving while its flag is already set is absorbed.
REQ-008 In IDLE with exactly one pending flag, SHALL grant that session next cycle and clear its flag.
REQ-009 In IDLE with both flags pending, SHALL grant the session type not granted last (round-robin); after reset, read wins first.
REQ-010 RD_CNT SHALL drive mem_rden=1, mem_address=0 for one cycle, then hold RD_CNT_WAIT until mem_q is valid, 2 cycles after issue.
REQ-011 Count SHALL be taken from mem_q[ADDR_WIDTH-1:0]; if count > PARTICLE_NUM-1, clamp to PARTICLE_NUM-1 and set err_ovf.
REQ-012 Count 0 SHALL produce no rd_valid; rd_done pulses in the cycle after the count is sampled, then FSM returns to IDLE.
REQ-013 RD_STREAM SHALL issue addresses 1..count on consecutive cycles with mem_rden=1, no bubbles.
REQ-014 rd_valid/rd_data/rd_id SHALL appear exactly 2 cycles after the matching issue; rd_last accompanies id==count.
REQ-015 RD_DRAIN SHALL wait for the last 2 returns; rd_done pulses in the cycle after rd_last, then IDLE.
REQ-016 WR_STREAM SHALL assert wr_ready; each accepted beat writes mem_wren=1 combinationally in the same cycle at address wr_ptr (start 1, +1 per stored beat).
REQ-017 A beat accepted when wr_ptr > PARTICLE_NUM-1 SHALL not be written (mem_wren=0), and SHALL set err_ovf.
REQ-018 The accepted beat with wr_last SHALL move the FSM to WR_CNT.
REQ-019 WR_CNT SHALL write address 0, mem_data = zero-extended stored-beat count, wr_ready=0, for one cycle; wr_done pulses that cycle; then IDLE.
REQ-020 mem_rden and mem_wren SHALL never be asserted in the same cycle.
REQ-021 SHALL ignore wr_valid outside WR_STREAM; wr_ready=0 outside WR_STREAM.

Reset
REQ-022 On rst, at next rising edge: FSM=IDLE; pending flags, round-robin pointer (read-first), counters, err_ovf cleared.
REQ-023 Outputs under reset: rd_valid, rd_last, rd_done, wr_ready, wr_done, busy, mem_rden, mem_wren = 0; rd_data, rd_id, mem_address, mem_data = 0.
REQ-024 Reset mid-session SHALL abandon it; in-flight RAM returns after reset SHALL not produce rd_valid.

Structure
REQ-025 FSM state enumeration and the 2-cycle read latency constant SHALL live in the shared define file.
REQ-026 A sub-module pos_cell_rd_tracker (2-stage valid/id/last shift register aligning returns with mem_q) SHALL be used.

Verification
REQ-027 RAM word0=3, rd_start -> rd_valid on 3 consecutive cycles, rd_id 1,2,3, rd_last with id 3, rd_done next cycle.
REQ-028 word0=0, rd_start -> no rd_valid; rd_done 4 cycles after grant (RD_CNT issue + 2 wait + 1); busy then 0.
REQ-029 wr_start, 5 beats with wr_valid gap after beat 2, wr_last on beat 5 -> writes addr 1..5, then addr 0 = 5, wr_done; subsequent read returns the 5 words.
REQ-030 rd_start and wr_start same cycle after reset -> read session first, write session immediately after; next simultaneous pair -> write first.
REQ-031 word0=250 -> count clamped to 219, err_ovf=1, 219 rd_valid beats; 221 write beats -> beat 220 onward dropped, addr 0 = 219, err_ovf=1.
REQ-032 rst asserted during RD_STREAM at id 2 of 10 -> no rd_valid after reset edge, busy=0, err_ovf=0, new rd_start works normally.
